// File: rtl/vc_dom_rr_arb4_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vc_dom_arb_pkg
//  Brief    : Shared encodings for the domain-aware round-robin arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package vc_dom_arb_pkg;

  // Width of the requestor index / mux select
  localparam int unsigned SEL_W = 2;

  // Arbiter FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCRUB = 2'd1;
  localparam logic [1:0] ST_LOCK  = 2'd2;

  // Security domain labels
  localparam logic DOM_NS = 1'b0;  // non-secure / L
  localparam logic DOM_S  = 1'b1;  // secure / H

endpackage
`default_nettype wire

// File: rtl/vc_dom_rr_arb4_if.sv
`default_nettype none
// ============================================================================
//  Module   : vc_dom_rr_arb4_if
//  Brief    : Requestor and channel signals of the domain-aware arbiter.
//             master = requestors plus downstream (traffic side),
//             slave  = the arbiter itself.
//  Revision : 1.0  initial release
// ============================================================================
interface vc_dom_rr_arb4_if;
  import vc_dom_arb_pkg::*;

  logic [3:0]       req_val;
  logic [3:0]       req_last;
  logic [3:0]       req_dom;
  logic [3:0]       req_rdy;
  logic             out_rdy;
  logic             out_val;
  logic [SEL_W-1:0] out_sel;
  logic             out_dom;
  logic             out_last;

  modport master (
    output req_val, req_last, req_dom, out_rdy,
    input  req_rdy, out_val, out_sel, out_dom, out_last
  );

  modport slave (
    input  req_val, req_last, req_dom, out_rdy,
    output req_rdy, out_val, out_sel, out_dom, out_last
  );

endinterface
`default_nettype wire

// File: rtl/vc_dom_rr_arb4_pick.sv
`default_nettype none
// ============================================================================
//  Module   : vc_rr_pick4
//  Brief    : Combinational 4-way round-robin picker. Returns the first set
//             bit of i_vec at or after i_ptr, wrapping 3 -> 0.
//  Revision : 1.0  initial release
// ============================================================================
module vc_rr_pick4
  import vc_dom_arb_pkg::*;
(
  input  logic [3:0]       i_vec,
  input  logic [SEL_W-1:0] i_ptr,
  output logic [SEL_W-1:0] o_idx,
  output logic             o_any
);

  logic [SEL_W-1:0] w_cand;

  // Scan from the farthest offset down so the nearest set bit wins last
  always_comb begin
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = '0;
    for (int k = 3; k >= 0; k--) begin
      w_cand = i_ptr + SEL_W'(k);
      if (i_vec[w_cand]) begin
        o_idx = w_cand;
        o_any = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/vc_dom_rr_arb4.sv
`default_nettype none
// ============================================================================
//  Module   : vc_dom_rr_arb4
//  Brief    : Four-requestor security-domain-aware round-robin arbiter.
//             Locks a grant for a whole message and inserts scrub bubbles
//             whenever the channel changes domain.
//  Revision : 1.0  initial release
// ============================================================================
module vc_dom_rr_arb4
  import vc_dom_arb_pkg::*;
#(
  parameter int unsigned p_scrub_cycles = 1   // legal range 1..15
)
(
  input  logic                   clk,
  input  logic                   reset_n,
  vc_dom_rr_arb4_if.slave        bus,
  output logic                   busy
);

  localparam logic [3:0] c_scrub_init = 4'(p_scrub_cycles - 1);

  logic [1:0]       state_q,     state_d;
  logic [SEL_W-1:0] rr_ptr_q,    rr_ptr_d;
  logic             cur_dom_q,   cur_dom_d;
  logic [3:0]       scrub_cnt_q, scrub_cnt_d;
  logic [SEL_W-1:0] sel_q,       sel_d;
  logic             dom_q,       dom_d;

  logic [SEL_W-1:0] w_win_idx;
  logic             w_win_any;
  logic             w_xfer;

  vc_rr_pick4 u_pick (
    .i_vec (bus.req_val),
    .i_ptr (rr_ptr_q),
    .o_idx (w_win_idx),
    .o_any (w_win_any)
  );

  // State and grant registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      cur_dom_q   <= DOM_NS;
      scrub_cnt_q <= '0;
      sel_q       <= '0;
      dom_q       <= DOM_NS;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cur_dom_q   <= cur_dom_d;
      scrub_cnt_q <= scrub_cnt_d;
      sel_q       <= sel_d;
      dom_q       <= dom_d;
    end
  end

  // Next-state: pick in IDLE, count bubbles in SCRUB, release on last beat
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cur_dom_d   = cur_dom_q;
    scrub_cnt_d = scrub_cnt_q;
    sel_d       = sel_q;
    dom_d       = dom_q;
    case (state_q)
      ST_IDLE: begin
        if (w_win_any) begin
          sel_d = w_win_idx;
          dom_d = bus.req_dom[w_win_idx];
          if (bus.req_dom[w_win_idx] == cur_dom_q) begin
            state_d = ST_LOCK;
          end else begin
            state_d     = ST_SCRUB;
            scrub_cnt_d = c_scrub_init;
          end
        end
      end
      ST_SCRUB: begin
        if (scrub_cnt_q == 4'd0) begin
          state_d   = ST_LOCK;
          cur_dom_d = dom_q;
        end else begin
          scrub_cnt_d = scrub_cnt_q - 4'd1;
        end
      end
      ST_LOCK: begin
        if (w_xfer && bus.out_last) begin
          state_d  = ST_IDLE;
          rr_ptr_d = sel_q + SEL_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs: the channel only carries beats while locked
  always_comb begin
    bus.out_val  = 1'b0;
    bus.out_last = 1'b0;
    bus.req_rdy  = '0;
    if (state_q == ST_LOCK) begin
      bus.out_val          = bus.req_val[sel_q];
      bus.out_last         = bus.req_last[sel_q];
      bus.req_rdy[sel_q]   = bus.out_rdy;
    end
  end

  assign w_xfer      = bus.out_val & bus.out_rdy;
  assign bus.out_sel = sel_q;
  assign bus.out_dom = dom_q;
  assign busy        = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_vc_dom_rr_arb4.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vc_dom_rr_arb4
//  Brief    : Directed self-checking bench for vc_dom_rr_arb4 (scrub = 2).
//  Revision : 1.0  initial release
// ============================================================================
module tb_vc_dom_rr_arb4;

  logic clk;
  logic reset_n;
  logic busy;
  int   n_checks;
  int   n_fail;

  vc_dom_rr_arb4_if u_if ();

  vc_dom_rr_arb4 #(.p_scrub_cycles(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (u_if),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    u_if.req_val   = 4'b0000;
    u_if.req_last  = 4'b0000;
    u_if.req_dom   = 4'b0000;
    u_if.out_rdy   = 1'b1;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n       = 1'b0;
    u_if.req_val  = 4'b0000;
    u_if.req_last = 4'b0000;
    u_if.req_dom  = 4'b0000;
    u_if.out_rdy  = 1'b1;
    tick();
    tick();
    check("rst_out_val",  32'(u_if.out_val),  0);
    check("rst_out_sel",  32'(u_if.out_sel),  0);
    check("rst_out_dom",  32'(u_if.out_dom),  0);
    check("rst_out_last", 32'(u_if.out_last), 0);
    check("rst_req_rdy",  32'(u_if.req_rdy),  0);
    check("rst_busy",     32'(busy),          0);
    reset_n = 1'b1;

    // 3-beat message from req1, then pointer must sit at 2
    u_if.req_val = 4'b0010;
    #1;
    check("t1_idle_busy", 32'(busy), 0);
    check("t1_idle_rdy",  32'(u_if.req_rdy), 0);
    tick();
    check("t1_b1_sel",  32'(u_if.out_sel),  1);
    check("t1_b1_val",  32'(u_if.out_val),  1);
    check("t1_b1_rdy",  32'(u_if.req_rdy),  2);
    check("t1_b1_last", 32'(u_if.out_last), 0);
    tick();
    check("t1_b2_rdy", 32'(u_if.req_rdy), 2);
    tick();
    u_if.req_last = 4'b0010;
    #1;
    check("t1_b3_last", 32'(u_if.out_last), 1);
    check("t1_b3_rdy",  32'(u_if.req_rdy),  2);
    tick();
    u_if.req_val  = 4'b0110;
    u_if.req_last = 4'b0110;
    #1;
    check("t1_post_busy", 32'(busy), 0);
    check("t1_post_sel",  32'(u_if.out_sel), 1);
    check("t1_post_val",  32'(u_if.out_val), 0);
    tick();
    check("t1_ptr2_sel", 32'(u_if.out_sel), 2);
    check("t1_ptr2_rdy", 32'(u_if.req_rdy), 4);
    tick();

    // All four requesting single-beat messages from pointer 0
    do_reset();
    u_if.req_val  = 4'b1111;
    u_if.req_last = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t2_idle_busy", 32'(busy), 0);
      tick();
      check("t2_sel",  32'(u_if.out_sel),  32'(k % 4));
      check("t2_val",  32'(u_if.out_val),  1);
      check("t2_last", 32'(u_if.out_last), 1);
      check("t2_busy", 32'(busy),          1);
      tick();
    end

    // Domain switch: req0 (NS) then req1 (S) with two scrub bubbles
    u_if.req_val  = 4'b0001;
    u_if.req_last = 4'b0001;
    u_if.req_dom  = 4'b0010;
    #1;
    check("t3_idle_busy", 32'(busy), 0);
    tick();
    u_if.req_val  = 4'b0011;
    u_if.req_last = 4'b0011;
    #1;
    check("t3_r0_sel", 32'(u_if.out_sel), 0);
    check("t3_r0_rdy", 32'(u_if.req_rdy), 1);
    check("t3_r0_dom", 32'(u_if.out_dom), 0);
    tick();
    u_if.req_val  = 4'b0010;
    u_if.req_last = 4'b0010;
    #1;
    check("t3_gap_busy", 32'(busy), 0);
    tick();
    for (int k = 0; k < 2; k++) begin
      check("t3_scr_busy", 32'(busy),          1);
      check("t3_scr_val",  32'(u_if.out_val),  0);
      check("t3_scr_rdy",  32'(u_if.req_rdy),  0);
      check("t3_scr_dom",  32'(u_if.out_dom),  1);
      check("t3_scr_sel",  32'(u_if.out_sel),  1);
      tick();
    end
    check("t3_lock_val", 32'(u_if.out_val), 1);
    check("t3_lock_rdy", 32'(u_if.req_rdy), 2);
    check("t3_lock_dom", 32'(u_if.out_dom), 1);
    tick();
    u_if.req_val = 4'b0000;

    // Backpressure on req2 (same domain S); req0 waits
    u_if.req_val  = 4'b0100;
    u_if.req_last = 4'b0000;
    u_if.req_dom  = 4'b0100;
    #1;
    check("t4_idle_busy", 32'(busy), 0);
    tick();
    check("t4_b1_rdy", 32'(u_if.req_rdy), 4);
    tick();
    u_if.out_rdy = 1'b0;
    u_if.req_val = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t4_bp_val", 32'(u_if.out_val), 1);
      check("t4_bp_rdy", 32'(u_if.req_rdy), 0);
      check("t4_bp_sel", 32'(u_if.out_sel), 2);
      tick();
    end
    u_if.out_rdy  = 1'b1;
    u_if.req_last = 4'b0100;
    #1;
    check("t4_end_rdy",  32'(u_if.req_rdy),  4);
    check("t4_end_last", 32'(u_if.out_last), 1);
    tick();
    u_if.req_val  = 4'b0001;
    u_if.req_last = 4'b0000;
    #1;
    check("t4_gap_busy", 32'(busy), 0);
    tick();
    check("t4_r0_busy", 32'(busy),         1);
    check("t4_r0_sel",  32'(u_if.out_sel), 0);
    check("t4_r0_dom",  32'(u_if.out_dom), 0);
    check("t4_r0_val",  32'(u_if.out_val), 0);
    tick();
    tick();

    // Reset during beat 2 of req0's 4-beat message
    check("t5_b1_rdy", 32'(u_if.req_rdy), 1);
    tick();
    check("t5_b2_val", 32'(u_if.out_val), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_rst_val",  32'(u_if.out_val),  0);
    check("t5_rst_rdy",  32'(u_if.req_rdy),  0);
    check("t5_rst_busy", 32'(busy),          0);
    check("t5_rst_last", 32'(u_if.out_last), 0);
    tick();
    reset_n       = 1'b1;
    u_if.req_val  = 4'b1001;
    u_if.req_last = 4'b1001;
    u_if.req_dom  = 4'b0000;
    #1;
    check("t5_idle_busy", 32'(busy), 0);
    tick();
    check("t5_regrant_sel", 32'(u_if.out_sel), 0);
    check("t5_regrant_rdy", 32'(u_if.req_rdy), 1);
    tick();

    // First secure request after reset must scrub
    do_reset();
    u_if.req_val  = 4'b1000;
    u_if.req_last = 4'b1000;
    u_if.req_dom  = 4'b1000;
    #1;
    check("t6_idle_busy", 32'(busy), 0);
    tick();
    check("t6_scr1_busy", 32'(busy),         1);
    check("t6_scr1_val",  32'(u_if.out_val), 0);
    check("t6_scr1_sel",  32'(u_if.out_sel), 3);
    check("t6_scr1_dom",  32'(u_if.out_dom), 1);
    tick();
    check("t6_scr2_val",  32'(u_if.out_val), 0);
    check("t6_scr2_busy", 32'(busy),         1);
    tick();
    check("t6_lock_val", 32'(u_if.out_val), 1);
    check("t6_lock_rdy", 32'(u_if.req_rdy), 8);
    tick();
    u_if.req_val = 4'b0000;
    #1;
    check("t6_done_busy", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
